// File: rtl/aes_dec_round_ctrl.sv
// Round sequencer for the iterative AES inverse cipher: walks the round-key index
// from NUM_ROUNDS down to 0, stalls on key availability and holds the result for the consumer.
module aes_dec_round_ctrl #(
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic       i_key_ready,
    input  logic       i_ack,
    output logic [3:0] o_key_idx,
    output logic       o_load_state,
    output logic       o_round_en,
    output logic       o_last_round,
    output logic       o_busy,
    output logic       o_valid
);

    // state | meaning
    // IDLE  | waiting for i_start
    // INIT  | load state with ciphertext ^ key[NUM_ROUNDS]
    // ROUND | full inverse rounds, key index rnd = NUM_ROUNDS-1 .. 1
    // FINAL | last inverse round (no inverse mix columns), key index 0
    // HOLD  | plaintext valid until i_ack
    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ROUND,
        S_FINAL,
        S_HOLD
    } state_e;

    localparam logic [3:0] KEY_INIT  = 4'(NUM_ROUNDS);
    localparam logic [3:0] KEY_FIRST = 4'(NUM_ROUNDS - 1);

    state_e     state_q, state_d;
    logic [3:0] rnd_q, rnd_d;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            rnd_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rnd_d        = rnd_q;
        o_key_idx    = 4'd0;
        o_load_state = 1'b0;
        o_round_en   = 1'b0;
        o_last_round = 1'b0;
        o_valid      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                o_key_idx    = KEY_INIT;
                o_load_state = i_key_ready;
                if (i_key_ready) begin
                    state_d = S_ROUND;
                    rnd_d   = KEY_FIRST;
                end
            end
            S_ROUND: begin
                o_key_idx  = rnd_q;
                o_round_en = i_key_ready;
                if (i_key_ready) begin
                    if (rnd_q == 4'd1) begin
                        state_d = S_FINAL;
                        rnd_d   = 4'd0;
                    end else begin
                        rnd_d = rnd_q - 4'd1;
                    end
                end
            end
            S_FINAL: begin
                o_last_round = 1'b1;
                o_round_en   = i_key_ready;
                if (i_key_ready) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                o_valid = 1'b1;
                if (i_ack) begin
                    // a start together with ack chains the next block with no idle gap
                    state_d = i_start ? S_INIT : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                rnd_d   = 4'd0;
            end
        endcase

        // abort wins over everything and suppresses any datapath write this cycle
        if (i_abort) begin
            state_d      = S_IDLE;
            rnd_d        = 4'd0;
            o_load_state = 1'b0;
            o_round_en   = 1'b0;
        end
    end

    assign o_busy = (state_q == S_INIT) || (state_q == S_ROUND) || (state_q == S_FINAL);

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Scoreboard bench for aes_dec_round_ctrl: stimulus pushes expected control events,
// a negedge monitor pops and compares them whenever the DUT issues a load/round/valid.
module tb_aes_dec_round_ctrl;

    logic       clk;
    logic       n_rst;
    logic       start, abort, kr, ack;
    logic [3:0] o_key_idx;
    logic       o_load_state, o_round_en, o_last_round, o_busy, o_valid;

    logic       s14, kr14, ack14;
    logic [3:0] idx14;
    logic       ld14, en14, last14, busy14, valid14;

    aes_dec_round_ctrl #(.NUM_ROUNDS(10)) dut (
        .clk(clk), .n_rst(n_rst),
        .i_start(start), .i_abort(abort), .i_key_ready(kr), .i_ack(ack),
        .o_key_idx(o_key_idx), .o_load_state(o_load_state), .o_round_en(o_round_en),
        .o_last_round(o_last_round), .o_busy(o_busy), .o_valid(o_valid)
    );

    aes_dec_round_ctrl #(.NUM_ROUNDS(14)) dut14 (
        .clk(clk), .n_rst(n_rst),
        .i_start(s14), .i_abort(1'b0), .i_key_ready(kr14), .i_ack(ack14),
        .o_key_idx(idx14), .o_load_state(ld14), .o_round_en(en14),
        .o_last_round(last14), .o_busy(busy14), .o_valid(valid14)
    );

    typedef struct {
        int         rel;
        logic       ld;
        logic       en;
        logic       last;
        logic [3:0] idx;
        logic       vld;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    int  t0 = 0;
    int  ld_cnt = 0;
    int  en_cnt = 0;
    logic vld_prev = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, want, $time);
        end
    endtask

    // monitor: one scoreboard entry per load pulse, round pulse or rising o_valid
    always @(negedge clk) begin
        ev_t e;
        if (n_rst && (o_load_state || o_round_en || (o_valid && !vld_prev))) begin
            if (o_load_state) ld_cnt++;
            if (o_round_en) en_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: rel=%0d ld=%b en=%b idx=%0d vld=%b, none expected",
                         cyc - t0, o_load_state, o_round_en, o_key_idx, o_valid);
            end else begin
                e = exp_q.pop_front();
                chk("event {rel,ld,en,last,idx,vld}",
                    {24'd0, 32'(cyc - t0), o_load_state, o_round_en, o_last_round, o_key_idx, o_valid},
                    {24'd0, 32'(e.rel), e.ld, e.en, e.last, e.idx, e.vld});
            end
        end
        vld_prev = n_rst ? o_valid : 1'b0;
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int rel, input logic ld, input logic en, input logic last,
                        input int idx, input logic vld);
        ev_t e;
        e.rel = rel; e.ld = ld; e.en = en; e.last = last; e.idx = 4'(idx); e.vld = vld;
        exp_q.push_back(e);
    endtask

    // expected timeline of one block; key-ready low during rel cycles [s_c, s_c+s_n)
    task automatic push_run(input int nr, input int s_c, input int s_n, input int stop_c);
        int c;
        if (1 < stop_c) push(1, 1'b1, 1'b0, 1'b0, nr, 1'b0);
        c = 2;
        for (int k = nr - 1; k >= 0; k--) begin
            while (c >= s_c && c < s_c + s_n) c++;
            if (c < stop_c) push(c, 1'b0, 1'b1, (k == 0), k, 1'b0);
            c++;
        end
        if (c < stop_c) push(c, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    endtask

    task automatic run_block(input int s_c, input int s_n, input int s_key, input int x1, input int x2);
        int ld0, en0;
        bit done;
        bit stall;
        done = 1'b0;
        push_run(10, s_c, s_n, 1000);
        ld0 = ld_cnt;
        en0 = en_cnt;
        start = 1'b1;
        kr = 1'b1;
        t0 = cyc;
        for (int c = 1; c <= 40 && !done; c++) begin
            tick;
            stall = (c >= s_c && c < s_c + s_n);
            start = (c == x1 || c == x2);
            ack = 1'b0;
            kr = !stall;
            #1;
            if (stall) begin
                chk("stall_key_idx", 64'(o_key_idx), 64'(s_key));
                chk("stall_round_en", 64'(o_round_en), 64'd0);
            end
            if (o_valid) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL valid_timeout: o_valid=0 after 40 cycles, expected 1");
        end
        @(negedge clk);
        #1;
        start = 1'b0;
        kr = 1'b1;
        chk("load_pulses", 64'(ld_cnt - ld0), 64'd1);
        chk("round_pulses", 64'(en_cnt - en0), 64'd10);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic release_hold;
        tick;
        ack = 1'b1;
        tick;
        ack = 1'b0;
        #1;
        chk("idle_after_ack {busy,valid}", {62'd0, o_busy, o_valid}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int vflag, c14, first14, nld, nen, nlast, lastc, vc;
        n_rst = 1'b0;
        start = 1'b0; abort = 1'b0; kr = 1'b1; ack = 1'b0;
        s14 = 1'b0; kr14 = 1'b1; ack14 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_outputs", {56'd0, o_key_idx, o_load_state, o_round_en, o_last_round, o_busy}, 64'd0);
        chk("reset_valid", 64'(o_valid), 64'd0);
        chk("reset_outputs_14", {56'd0, idx14, ld14, en14, last14, busy14}, 64'd0);
        n_rst = 1'b1;
        tick;
        #1;
        chk("idle_after_reset", {59'd0, o_key_idx, o_busy}, 64'd0);

        // nominal block, key always ready
        run_block(0, 0, 0, 0, 0);
        release_hold;

        // key not ready for 3 cycles while key index is 5
        run_block(6, 3, 5, 0, 0);
        release_hold;

        // hold with no ack for 4 cycles, then ack+start back-to-back
        run_block(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick;
            #1;
            chk("hold_valid", 64'(o_valid), 64'd1);
        end
        ack = 1'b1;
        run_block(0, 0, 0, 0, 0);
        release_hold;

        // abort while key index is 6
        push_run(10, 0, 0, 5);
        start = 1'b1;
        t0 = cyc;
        for (int c = 1; c <= 4; c++) begin
            tick;
            start = 1'b0;
        end
        tick;
        abort = 1'b1;
        #1;
        chk("abort_key_idx", 64'(o_key_idx), 64'd6);
        chk("abort_en_ld", {62'd0, o_round_en, o_load_state}, 64'd0);
        tick;
        abort = 1'b0;
        #1;
        chk("after_abort {busy,idx}", {59'd0, o_busy, o_key_idx}, 64'd0);
        vflag = 0;
        for (int i = 0; i < 15; i++) begin
            tick;
            if (o_valid) vflag = 1;
        end
        chk("no_valid_after_abort", 64'(vflag), 64'd0);
        chk("abort_queue_drained", 64'(exp_q.size()), 64'd0);
        run_block(0, 0, 0, 0, 0);
        release_hold;

        // asynchronous reset mid-round
        push_run(10, 0, 0, 4);
        start = 1'b1;
        t0 = cyc;
        for (int c = 1; c <= 3; c++) begin
            tick;
            start = 1'b0;
        end
        tick;
        n_rst = 1'b0;
        #1;
        chk("async_reset_outputs", {58'd0, o_key_idx, o_load_state, o_round_en, o_last_round, o_busy, o_valid}, 64'd0);
        tick;
        n_rst = 1'b1;
        #1;
        chk("after_reset_idle", {58'd0, o_key_idx, o_load_state, o_round_en, o_last_round, o_busy, o_valid}, 64'd0);
        chk("reset_queue_drained", 64'(exp_q.size()), 64'd0);

        // starts while busy are ignored; start in HOLD without ack is ignored too
        run_block(0, 0, 0, 3, 7);
        tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        ack = 1'b1;
        tick;
        ack = 1'b0;
        tick;
        #1;
        chk("no_queued_start {busy,valid}", {62'd0, o_busy, o_valid}, 64'd0);
        tick;
        #1;
        chk("still_idle", 64'(o_busy), 64'd0);

        // NUM_ROUNDS=14 instance
        first14 = -1; nld = 0; nen = 0; nlast = 0; lastc = 0; vc = 0;
        s14 = 1'b1;
        tick;
        s14 = 1'b0;
        for (c14 = 1; c14 <= 30; c14++) begin
            #1;
            if (ld14) begin
                nld++;
                if (first14 < 0) first14 = int'(idx14);
            end
            if (en14) nen++;
            if (last14) begin
                nlast++;
                lastc = c14;
            end
            if (valid14) begin
                vc = c14;
                break;
            end
            tick;
        end
        chk("nr14_first_key_idx", 64'(first14), 64'd14);
        chk("nr14_load_pulses", 64'(nld), 64'd1);
        chk("nr14_round_pulses", 64'(nen), 64'd14);
        chk("nr14_last_round {count,cycle}", {32'(nlast), 32'(lastc)}, {32'd1, 32'd15});
        chk("nr14_valid_cycle", 64'(vc), 64'd16);
        tick;
        ack14 = 1'b1;
        tick;
        ack14 = 1'b0;
        #1;
        chk("nr14_idle_after_ack", {62'd0, busy14, valid14}, 64'd0);

        repeat (3) tick;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
